pow_share_arbiter: RTL and testbench
====================================

# pow_share_arbiter

Shares one iterative 18-bit power unit (repeated multiply of a latched base) between `N_REQ` requesters. Round-robin arbitration picks a requester, latches its base and exponent, and runs the multiply loop. The result is returned with a one-hot completion pulse to the winner. It sits between client blocks that need n^k (mod 2^W) and the single multiplier resource, so replicated pipelined multipliers are not needed.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `W`, 18: base/result width; all arithmetic is mod 2^W.
- `EXP_W`, 3: exponent width; k ranges 0..2^EXP_W−1.

- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  request per requester; level, held until grant.
- `n`  in  N_REQ*W  bases; requester i at bits [i*W +: W].
- `k`  in  N_REQ*EXP_W  exponents; requester i at bits [i*EXP_W +: EXP_W].
- `grant`  out  N_REQ  one-hot, one-cycle pulse: request accepted, operands latched.
- `done`  out  N_REQ  one-hot, one-cycle pulse: result valid for that requester.
- `result`  out  W  n^k mod 2^W of the last completed job; held until the next done.
- `busy`  out  1  high while a job is in progress.

## Operation
- States: IDLE, CALC. Registers: `r_n`[W], `acc`[W], `cnt`[EXP_W], `id` (one-hot), `last` (index of the last winner).
- **IDLE, req≠0 at an edge:**
  - Winner is the first set bit of `req` scanning `last`+1, `last`+2, … mod N_REQ.
  - Load `r_n`←n[winner], `cnt`←k[winner], `acc`←1, `id`←winner, `last`←winner.
  - Set `grant`←onehot(winner) and go to CALC.
- **IDLE, req=0:** hold; `grant`=0.
- **CALC, cnt≠0:** `acc`←(acc*r_n)[W-1:0], `cnt`←cnt−1.
- **CALC, cnt=0:** `result`←acc, `done`←id, return to IDLE.
- `grant` and `done` are registered and high for exactly one cycle each.
- `busy` = (state==CALC), registered.
- Requester protocol:
  - Hold `req`, `n`, `k` stable until `grant` is seen.
  - Drop `req` in the cycle `grant` is high; `req` and operands are don't-care after grant.
  - A `req` still high at the next IDLE edge is treated as a new request.
- `req` changes during CALC are ignored, with no effect on the running job.
- k=0 gives result 1 for any n, including n=0. n=0 with k>0 gives 0.
- Products are truncated to the low W bits every step; there is no saturation or overflow flag.
- **Reset, asynchronous, any state:**
  - state=IDLE, `grant`=0, `done`=0, `result`=0, `busy`=0, `acc`=0, `cnt`=0, `last`=N_REQ−1 (requester 0 has first priority).
  - A job in flight is discarded; no done is produced for it.

## Timing
- Edge E0 (IDLE, req≠0): grant high for the cycle after E0; busy rises at the same time.
- Edges E1..Ek: multiplies.
- Edge E(k+1): done and result update, busy falls.
- Latency from grant to done is k+1 cycles.
- The earliest next grant is at edge E(k+2), so a back-to-back job has one IDLE cycle between jobs.
- Throughput per job is k+2 cycles.
- A grant and a done never occur in the same cycle.
- The multiply path is one W×W multiply, truncated, per cycle.

## Test plan
- Single job: req0, n=3, k=5 → grant=0001 for 1 cycle; done=0001 exactly 6 cycles after grant; result=243; busy high for 6 cycles.
- Edge exponents:
  - n=7, k=0 → done 1 cycle after grant, result=1.
  - n=2, k=7 → result=128.
  - n=0, k=3 → result=0.
- Wrap-around arithmetic: n=1000, k=2 → result=213568 (1000000 mod 262144).
- Simultaneous requests: all four req high with k=1, each dropping req after its own grant → grants in order 0001, 0010, 0100, 1000. Each done matches its grant, and result equals each n.
- Round-robin fairness: after requester 0 wins, req0 and req2 both high → next grant=0100; a later req0 alone → 0001.
- Reset mid-op: reset_n low for 2 cycles during CALC of a k=7 job → grant, done, busy and result all 0 immediately. No done for the aborted job; the next request with req1 is granted normally.

Source files
------------

// File: rtl/pow_share_arbiter.sv
// pow_share_arbiter: round-robin share of one iterative power unit.
// Each job computes n^k mod 2^W with one truncated multiply per cycle.
module pow_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 18,
   parameter int EXP_W = 3
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*W-1:0]     n,
   input  logic [N_REQ*EXP_W-1:0] k,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic [W-1:0]           result,
   output logic                   busy
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {
      S_IDLE,
      S_CALC
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [W-1:0]       r_n;
   logic [W-1:0]       r_acc;
   logic [EXP_W-1:0]   r_cnt;
   logic [N_REQ-1:0]   r_id;
   logic [IW-1:0]      r_last;

   logic [W-1:0]       w_n_arr [N_REQ];
   logic [EXP_W-1:0]   w_k_arr [N_REQ];
   logic [IW:0]        w_j;
   logic [IW-1:0]      w_jj;
   logic [IW-1:0]      w_win;
   logic [N_REQ-1:0]   w_oh;
   logic               w_any;
   logic [W-1:0]       w_n_sel;
   logic [EXP_W-1:0]   w_k_sel;
   logic               w_load;
   logic               w_step;
   logic               w_fin;
   logic [W-1:0]       w_mul;

   // unpack the flat operand buses into per-requester lanes
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         w_n_arr[i] = n[i*W +: W];
         w_k_arr[i] = k[i*EXP_W +: EXP_W];
      end
   end

   // round-robin pick: scan far-to-near so the nearest set bit after last wins
   always_comb begin
      w_any   = 1'b0;
      w_oh    = '0;
      w_win   = '0;
      w_j     = '0;
      w_jj    = '0;
      w_n_sel = '0;
      w_k_sel = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         w_j = {1'b0, r_last} + (IW+1)'(i);
         if (w_j >= (IW+1)'(N_REQ))
            w_j = w_j - (IW+1)'(N_REQ);
         w_jj = w_j[IW-1:0];
         if (req[w_jj]) begin
            w_any     = 1'b1;
            w_win     = w_jj;
            w_oh      = '0;
            w_oh[w_jj] = 1'b1;
            w_n_sel   = w_n_arr[w_jj];
            w_k_sel   = w_k_arr[w_jj];
         end
      end
   end

   // one truncated W x W multiply per cycle
   assign w_mul = r_acc * r_n;

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // next state and datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_fin       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_load      = 1'b1;
               w_state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            if (r_cnt != '0) begin
               w_step = 1'b1;
            end else begin
               w_fin       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // operand latch, multiply loop and registered pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_n    <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_id   <= '0;
         r_last <= IW'(N_REQ - 1);
         grant  <= '0;
         done   <= '0;
         result <= '0;
         busy   <= 1'b0;
      end else begin
         grant <= w_load ? w_oh : '0;
         done  <= w_fin ? r_id : '0;
         busy  <= (w_state_nxt == S_CALC);
         if (w_load) begin
            r_n    <= w_n_sel;
            r_cnt  <= w_k_sel;
            r_acc  <= W'(1);
            r_id   <= w_oh;
            r_last <= w_win;
         end
         if (w_step) begin
            r_acc <= w_mul;
            r_cnt <= r_cnt - EXP_W'(1);
         end
         if (w_fin)
            result <= r_acc;
      end
   end

endmodule

// File: tb/tb_pow_share_arbiter.sv
// tb_pow_share_arbiter: directed and random jobs checked every cycle
// against a job-timeline model of the shared power unit.
module tb_pow_share_arbiter;

   localparam int N  = 4;
   localparam int W  = 18;
   localparam int EW = 3;

   logic              clock;
   logic              reset_n;
   logic [N-1:0]      req;
   logic [N*W-1:0]    n;
   logic [N*EW-1:0]   k;
   logic [N-1:0]      grant;
   logic [N-1:0]      done;
   logic [W-1:0]      result;
   logic              busy;

   int errors = 0;
   int checks = 0;

   pow_share_arbiter #(.N_REQ(N), .W(W), .EXP_W(EW)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .n(n), .k(k),
      .grant(grant), .done(done), .result(result), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] mpow(input logic [W-1:0] b,
                                         input int e);
      logic [W-1:0] r;
      r = W'(1);
      for (int i = 0; i < e; i++) r = r * b;
      return r;
   endfunction

   // ---------------- reference model: job timeline ----------------
   longint       e_cnt, g_edge, d_edge, free_edge;
   int           last_w, cur_win, kk;
   logic [W-1:0] job_res, m_result;
   logic [N-1:0] m_grant, m_done, win_oh;
   logic         m_busy;
   bit           found;

   initial begin
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) begin
            e_cnt = 0; g_edge = -10; d_edge = -10; free_edge = 0;
            last_w = N - 1; cur_win = 0; win_oh = '0;
            m_result = '0; m_grant = '0; m_done = '0; m_busy = 1'b0;
         end else begin
            e_cnt++;
            if (e_cnt == d_edge) m_result = job_res;
            if (e_cnt >= free_edge && req != '0) begin
               found = 0;
               for (int s = 1; s <= N; s++) begin
                  if (!found && req[(last_w + s) % N]) begin
                     found = 1;
                     cur_win = (last_w + s) % N;
                  end
               end
               kk = int'(k[cur_win*EW +: EW]);
               job_res = mpow(n[cur_win*W +: W], kk);
               g_edge = e_cnt;
               d_edge = e_cnt + kk + 1;
               free_edge = e_cnt + kk + 2;
               last_w = cur_win;
               win_oh = '0;
               win_oh[cur_win] = 1'b1;
            end
            m_grant = (e_cnt == g_edge) ? win_oh : '0;
            m_done  = (e_cnt == d_edge) ? win_oh : '0;
            m_busy  = (e_cnt >= g_edge) && (e_cnt < d_edge);
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clock) begin
      if (reset_n) begin
         chk("m_grant", 32'(grant), 32'(m_grant));
         chk("m_done", 32'(done), 32'(m_done));
         chk("m_busy", 32'(busy), 32'(m_busy));
         chk("m_result", 32'(result), 32'(m_result));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_grant(output logic [N-1:0] g, output int c);
      g = '0; c = 0;
      while (g == '0 && c < 60) begin
         @(negedge clock);
         c++;
         g = grant;
      end
      req = req & ~g;
      if (g == '0) chk("grant_timeout", 0, 1);
   endtask

   task automatic wait_done(output logic [N-1:0] d, output int c,
                            output int bc);
      d = '0; c = 0; bc = 0;
      while (d == '0 && c < 60) begin
         @(negedge clock);
         c++;
         d = done;
         if (busy) bc++;
      end
      if (d == '0) chk("done_timeout", 0, 1);
   endtask

   task automatic run_job(input int idx, input logic [W-1:0] nv,
                          input int kv, input logic [W-1:0] exp_res,
                          input int exp_lat, input string nm);
      logic [N-1:0] g, d;
      int c, bc;
      @(negedge clock); #1;
      n[idx*W +: W]   = nv;
      k[idx*EW +: EW] = EW'(kv);
      req[idx]        = 1'b1;
      wait_grant(g, c);
      chk({nm, "_grant"}, 32'(g), 32'(1) << idx);
      chk({nm, "_busy_at_grant"}, 32'(busy), 1);
      wait_done(d, c, bc);
      chk({nm, "_latency"}, c, exp_lat);
      chk({nm, "_busy_cycles"}, bc + 1, exp_lat);
      chk({nm, "_done"}, 32'(d), 32'(1) << idx);
      chk({nm, "_result"}, 32'(result), 32'(exp_res));
   endtask

   logic [N-1:0] g_ord [N];
   logic [W-1:0] nlist [N];
   logic [N-1:0] gg, dd;
   int gi, di, cc, bb, sel;
   bit raise;

   initial begin
      reset_n = 1'b0;
      req = '0; n = '0; k = '0;
      chk("pin_pow_3_5", 32'(mpow(3, 5)), 243);
      chk("pin_pow_1000_2", 32'(mpow(1000, 2)), 213568);
      chk("pin_pow_0_0", 32'(mpow(0, 0)), 1);
      repeat (2) @(posedge clock);
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_busy", 32'(busy), 0);
      @(negedge clock); #2 reset_n = 1'b1;

      run_job(0, 3, 5, 243, 6, "single");
      run_job(0, 7, 0, 1, 1, "k0");
      run_job(2, 2, 7, 128, 8, "k7");
      run_job(1, 0, 3, 0, 4, "n0");
      run_job(3, 1000, 2, 213568, 3, "wrap");

      // all four requesters at once, k=1
      @(negedge clock); #1;
      for (int i = 0; i < N; i++) begin
         nlist[i] = W'(11 * (i + 1));
         n[i*W +: W] = nlist[i];
         k[i*EW +: EW] = EW'(1);
      end
      req = '1;
      gi = 0; di = 0; cc = 0;
      while ((gi < N || di < N) && cc < 60) begin
         @(negedge clock);
         cc++;
         if (grant != '0 && gi < N) begin
            g_ord[gi] = grant;
            req = req & ~grant;
            gi++;
         end
         if (done != '0 && di < N) begin
            chk("sim_done_match", 32'(done), 32'(g_ord[di]));
            chk("sim_result", 32'(result), 32'(nlist[di]));
            di++;
         end
      end
      chk("sim_all_done", di, N);
      for (int i = 0; i < N; i++)
         chk("sim_grant_order", 32'(g_ord[i]), 32'(1) << i);

      // fairness: after 0 wins, 0 and 2 both ask
      run_job(0, 5, 1, 5, 2, "rr_first");
      @(negedge clock); #1;
      n[0*W +: W] = 6;  k[0*EW +: EW] = 1;
      n[2*W +: W] = 9;  k[2*EW +: EW] = 1;
      req = 4'b0101;
      wait_grant(gg, cc);
      chk("rr_grant_2", 32'(gg), 4);
      req[0] = 1'b1;
      wait_grant(gg, cc);
      chk("rr_grant_0", 32'(gg), 1);
      wait_done(dd, cc, bb);
      chk("rr_done_0", 32'(dd), 1);
      chk("rr_result_0", 32'(result), 6);

      // randomized traffic
      raise = 1;
      cc = 0;
      while (cc < 1500) begin
         @(negedge clock); #1;
         cc++;
         if (cc > 1200) raise = 0;
         for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
               req[i] = 1'b0;
            end else if (raise && !req[i] && $urandom_range(0, 3) == 0) begin
               sel = $urandom_range(0, 3);
               if (sel == 0) n[i*W +: W] = '0;
               else if (sel == 1) n[i*W +: W] = W'($urandom_range(0, 15));
               else n[i*W +: W] = W'($urandom_range(0, 262143));
               k[i*EW +: EW] = EW'($urandom_range(0, 7));
               req[i] = 1'b1;
            end
         end
         if (!raise && req == '0 && !busy) cc = 1500;
      end
      chk("rand_drained", 32'(req), 0);
      repeat (3) @(negedge clock);

      // reset in the middle of a k=7 job
      @(negedge clock); #1;
      n[0*W +: W] = 5; k[0*EW +: EW] = 7; req[0] = 1'b1;
      wait_grant(gg, cc);
      chk("abort_grant", 32'(gg), 1);
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_grant_clr", 32'(grant), 0);
      chk("abort_done_clr", 32'(done), 0);
      chk("abort_busy_clr", 32'(busy), 0);
      chk("abort_result_clr", 32'(result), 0);
      repeat (2) @(posedge clock);
      @(negedge clock); #2 reset_n = 1'b1;
      run_job(1, 3, 2, 9, 3, "after_rst");
      repeat (12) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
